mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single-port program/data memory between two requesters: port 0 is the CPU fetch/load/store path and port 1 is the DMA/loader path.
- Owns the memory control strobes and runs one transaction at a time with a req/ack handshake.
- Uses round-robin fairness, an optional lock for atomic sequences, and a timeout if the memory never returns ready.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width (matches 16-bit instruction word)
TIMEOUT, 15, maximum ACCESS cycles waiting for mem_ready before error completion (1..255)
LOCK_MAX, 4, maximum consecutive locked transactions by one owner before forced release (1..15)

Ports:
clk  in  1  system clock, rising edge
reset_cycle  in  1  asynchronous active-high reset
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0 write enable (1=write, 0=read)
lock0  in  1  port 0 wants bus retained after this transaction
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 transaction complete, one-cycle pulse
req1, we1, lock1, addr1, wdata1  in  1/1/1/ADDR_W/DATA_W  port 1, same semantics as port 0
ack1  out  1  port 1 completion pulse
rdata  out  DATA_W  read data, valid while ackN=1 for a read
err  out  1  asserted with ackN when the transaction timed out
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
mem_ready  in  1  memory completes the access this cycle
busy  out  1  1 whenever the state is not IDLE
owner  out  1  index of the current or most recent owner

Behaviour:
- Reset (async, reset_cycle=1):
  - State=IDLE; all outputs 0.
  - last_served=1, so port 0 wins the first tie.
  - lock_active=0, lock_cnt=0, timeout counter=0.
  - Any in-flight access is abandoned with no ack.
- All outputs are registered. FSM states are IDLE, ACCESS and RESP.
- IDLE, evaluated at each rising edge:
  - If lock_active: only owner is eligible. Grant it if its req=1; otherwise stay IDLE. The other port waits.
  - Else if both req: grant the port != last_served.
  - Else grant the single requester.
  - No req: stay IDLE.
  - On grant: owner<=sel; latch addrN/weN/wdataN into mem_addr/mem_we/mem_wdata; mem_en<=1; timeout counter<=0; go ACCESS.
- ACCESS:
  - mem_en=1; mem_addr, mem_we and mem_wdata stay stable.
  - If mem_ready=1: rdata<=mem_rdata (reads only; writes leave rdata unchanged); err<=0; go RESP.
  - Else if counter==TIMEOUT-1: err<=1; rdata<=0; go RESP.
  - Else counter+1.
- RESP:
  - mem_en=0, mem_we=0; ack[owner]=1 for exactly one cycle; last_served<=owner.
  - Lock update, using lockN of the owner sampled in this cycle:
    - lock=1 and lock_cnt<LOCK_MAX-1: lock_active<=1, lock_cnt+1.
    - Otherwise: lock_active<=0, lock_cnt<=0. This covers the forced release at LOCK_MAX.
  - A timed-out transaction always clears lock_active.
  - Always go IDLE.
- Handshake rules:
  - The requester holds req and its request fields stable until it samples ackN=1, then drops req at that edge or issues a new request.
  - Request field changes before ack are ignored after the IDLE capture.
  - req high during ACCESS/RESP is not a new request.
  - Dropping req during ACCESS does not abort the transaction; the ack is still issued.
- Latency: with mem_ready tied 1, req sampled at edge E gives ACCESS in cycle E..E+1 and ack in cycle E+1..E+2. Back-to-back throughput is one transaction per 3 cycles.
- Simultaneous events:
  - With both ports requesting continuously and no lock, grants alternate 0,1,0,1…
  - A locked owner can delay the other port by at most LOCK_MAX transactions.
- ack0 and ack1 are never both 1. ack and err are never 1 in IDLE or ACCESS.

Test Plan:
1. Reset, then req0 read addr 0x0010 with mem_ready=1 and mem_rdata=0xA5A5 -> mem_en high one cycle with mem_addr=0x0010, ack0 next cycle with rdata=0xA5A5, err=0, busy back to 0.
2. req0 and req1 both held continuously for 4 transactions -> owner sequence 0,1,0,1; each ack pulses exactly one cycle; never both acks.
3. Port 1 write 0x1234 to 0x00FF with mem_ready delayed 3 cycles -> mem_we/mem_addr/mem_wdata stable for 4 ACCESS cycles, ack1 then, rdata unchanged.
4. Port 0 with lock0=1 for 6 transactions while req1 held -> port 0 served 4 times (LOCK_MAX), then port 1 granted.
5. mem_ready held 0 -> after TIMEOUT=15 ACCESS cycles, ack=1 and err=1, rdata=0, lock_active cleared.
6. Assert reset_cycle mid-ACCESS -> all outputs 0 asynchronously, no ack; after release, a req1-only request is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one single-port memory
// between the CPU path (port 0) and the DMA/loader path (port 1).
// Ports: clk, reset_cycle (async, active-high);
//   reqN/weN/lockN/addrN/wdataN in, ackN out (N = 0, 1);
//   rdata/err shared completion data; mem_en/mem_we/mem_addr/mem_wdata
//   to memory, mem_rdata/mem_ready from memory; busy, owner status.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int TIMEOUT  = 15,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_cycle,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] LK_LAST = 4'(LOCK_MAX - 1);

  state_t state, state_d;

  logic              last_q, last_d;
  logic              lk_act, lk_act_d;
  logic [3:0]        lk_cnt, lk_cnt_d;
  logic [7:0]        to_cnt, to_cnt_d;
  logic              owner_d, busy_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              err_d, ack0_d, ack1_d;
  logic              grant, sel, own_lock;

  always_comb begin
    state_d     = state;
    last_d      = last_q;
    lk_act_d    = lk_act;
    lk_cnt_d    = lk_cnt;
    to_cnt_d    = to_cnt;
    owner_d     = owner;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rdata_d     = rdata;
    err_d       = err;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    grant       = 1'b0;
    sel         = 1'b0;
    own_lock    = owner ? lock1 : lock0;

    unique case (state)
      IDLE: begin
        // A held lock excludes the other port entirely.
        if (lk_act) begin
          sel   = owner;
          grant = owner ? req1 : req0;
        end else if (req0 && req1) begin
          sel   = ~last_q;
          grant = 1'b1;
        end else begin
          sel   = req1 & ~req0;
          grant = req0 | req1;
        end
        if (grant) begin
          owner_d     = sel;
          mem_addr_d  = sel ? addr1 : addr0;
          mem_we_d    = sel ? we1 : we0;
          mem_wdata_d = sel ? wdata1 : wdata0;
          mem_en_d    = 1'b1;
          to_cnt_d    = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready || to_cnt == TO_LAST) begin
          if (mem_ready) begin
            if (!mem_we) rdata_d = mem_rdata;
            err_d = 1'b0;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          ack0_d   = ~owner;
          ack1_d   = owner;
          state_d  = RESP;
        end else begin
          to_cnt_d = to_cnt + 8'd1;
        end
      end
      RESP: begin
        last_d = owner;
        // err here marks a timed-out access, which never keeps the lock.
        if (!err && own_lock && lk_cnt < LK_LAST) begin
          lk_act_d = 1'b1;
          lk_cnt_d = lk_cnt + 4'd1;
        end else begin
          lk_act_d = 1'b0;
          lk_cnt_d = '0;
        end
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state     <= IDLE;
      last_q    <= 1'b1;
      lk_act    <= 1'b0;
      lk_cnt    <= '0;
      to_cnt    <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      state     <= state_d;
      last_q    <= last_d;
      lk_act    <= lk_act_d;
      lk_cnt    <= lk_cnt_d;
      to_cnt    <= to_cnt_d;
      owner     <= owner_d;
      busy      <= busy_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rdata     <= rdata_d;
      err       <= err_d;
      ack0      <= ack0_d;
      ack1      <= ack1_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed + random transactions for
// mem_bus_arbiter, checked against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int TO = 15;
  localparam int LM = 4;

  logic        clk = 1'b0;
  logic        reset_cycle = 1'b1;
  logic        req0 = 0, we0 = 0, lock0 = 0;
  logic [15:0] addr0 = 0, wdata0 = 0;
  logic        req1 = 0, we1 = 0, lock1 = 0;
  logic [15:0] addr1 = 0, wdata1 = 0;
  logic        ack0, ack1, err, mem_en, mem_we, busy, owner;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 0;
  logic        mem_ready = 0;

  mem_bus_arbiter #(
    .ADDR_W(16), .DATA_W(16), .TIMEOUT(TO), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .reset_cycle(reset_cycle),
    .req0(req0), .we0(we0), .lock0(lock0),
    .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .lock1(lock1),
    .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!reset_cycle) begin
      chk("ack_excl", 32'(ack0 & ack1), 0);
      chk("err_no_ack", 32'(err & ~(ack0 | ack1)), 0);
    end

  // Reference model state
  bit          pend[2];
  bit          p_we[2], p_lock[2];
  logic [15:0] p_addr[2], p_wdata[2];
  logic [15:0] mem_m[64];
  int          m_last, m_lkcnt;
  bit          m_lk;
  logic [15:0] m_rdata;
  logic [7:0]  own_hist;

  task automatic set_req(input int p, input bit w, input bit lk,
                         input logic [15:0] a, input logic [15:0] d);
    pend[p] = 1; p_we[p] = w; p_lock[p] = lk;
    p_addr[p] = a; p_wdata[p] = d;
  endtask

  task automatic drive();
    req0 = pend[0]; we0 = p_we[0]; lock0 = p_lock[0];
    addr0 = p_addr[0]; wdata0 = p_wdata[0];
    req1 = pend[1]; we1 = p_we[1]; lock1 = p_lock[1];
    addr1 = p_addr[1]; wdata1 = p_wdata[1];
  endtask

  task automatic model_reset();
    m_last = 1; m_lk = 0; m_lkcnt = 0; m_rdata = 0;
    pend[0] = 0; pend[1] = 0;
    mem_ready = 0;
    drive();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        32'({ack0, ack1, err, mem_en, mem_we, busy, owner}), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
  endtask

  task automatic do_reset();
    reset_cycle = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_cycle = 0;
  endtask

  // One arbitration opportunity; lat is the ACCESS cycle in which
  // mem_ready rises (beyond TO means it never does).
  task automatic step(input int lat, input bit drop);
    int w, n, idx;
    bit to, ok;
    logic [15:0] rd;
    if (m_lk) w = pend[m_last] ? m_last : -1;
    else if (pend[0] && pend[1]) w = 1 - m_last;
    else if (pend[0]) w = 0;
    else if (pend[1]) w = 1;
    else w = -1;
    drive();
    @(posedge clk);
    #1;
    if (w < 0) begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_en", 32'(mem_en), 0);
      return;
    end
    own_hist = {own_hist[6:0], owner};
    chk("grant_owner", 32'(owner), w);
    chk("grant_en", 32'(mem_en), 1);
    chk("grant_addr", 32'(mem_addr), 32'(p_addr[w]));
    chk("grant_we", 32'(mem_we), 32'(p_we[w]));
    chk("grant_wdata", 32'(mem_wdata), 32'(p_wdata[w]));
    chk("grant_busy", 32'(busy), 1);
    chk("grant_noack", 32'({ack1, ack0}), 0);
    if (drop) begin
      if (w == 0) begin
        req0 = 0; addr0 = 16'($urandom); wdata0 = 16'($urandom);
      end else begin
        req1 = 0; addr1 = 16'($urandom); wdata1 = 16'($urandom);
      end
    end
    to = lat > TO;
    n = to ? TO : lat;
    idx = int'(p_addr[w][5:0]);
    ok = 1;
    for (int i = 1; i <= n; i++) begin
      mem_ready = (i == lat);
      mem_rdata = (i == lat) ? mem_m[idx] : 16'($urandom);
      @(posedge clk);
      #1;
      if (i < n)
        ok &= mem_en && !ack0 && !ack1 &&
              mem_addr == p_addr[w] && mem_we == p_we[w] &&
              mem_wdata == p_wdata[w];
    end
    mem_ready = 0;
    if (to) rd = 0;
    else if (p_we[w]) rd = m_rdata;
    else rd = mem_m[idx];
    if (!to && p_we[w]) mem_m[idx] = p_wdata[w];
    m_rdata = rd;
    chk("acc_stable", 32'(ok), 1);
    chk("resp_ack", 32'({ack1, ack0}), (w == 1) ? 2 : 1);
    chk("resp_err", 32'(err), 32'(to));
    chk("resp_rdata", 32'(rdata), 32'(rd));
    chk("resp_en", 32'({mem_en, mem_we}), 0);
    m_last = w;
    if (!to && p_lock[w] && m_lkcnt < LM - 1) begin
      m_lk = 1; m_lkcnt++;
    end else begin
      m_lk = 0; m_lkcnt = 0;
    end
    pend[w] = 0;
    @(posedge clk);
    #1;
    chk("post_ack", 32'({ack1, ack0, err}), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    for (int i = 0; i < 64; i++) mem_m[i] = 16'($urandom);
    own_hist = 0;

    // Single read
    do_reset();
    mem_m[16] = 16'hA5A5;
    set_req(0, 0, 0, 16'h0010, 16'h0);
    step(1, 0);
    chk("t1_rdata", 32'(rdata), 32'h0000A5A5);

    // Continuous contention alternates
    do_reset();
    own_hist = 0;
    for (int k = 0; k < 4; k++) begin
      if (!pend[0]) set_req(0, 0, 0, 16'h0020 + 16'(k), 0);
      if (!pend[1]) set_req(1, 1, 0, 16'h0030 + 16'(k), 16'(k));
      step(1, 0);
    end
    chk("t2_order", 32'(own_hist[3:0]), 32'b0101);

    // Delayed write leaves rdata alone
    set_req(1, 1, 0, 16'h00FF, 16'h1234);
    step(4, 0);

    // Lock limit
    do_reset();
    own_hist = 0;
    set_req(1, 0, 0, 16'h0200, 0);
    for (int k = 0; k < 6; k++) begin
      if (!pend[0]) set_req(0, 0, 1, 16'h0100 + 16'(k), 0);
      step(1, 0);
    end
    chk("t4_order", 32'(own_hist[5:0]), 32'b000010);

    // Timeout under lock, then lock must be gone
    set_req(0, 0, 1, 16'h0040, 0);
    step(TO + 5, 0);
    set_req(0, 0, 1, 16'h0041, 0);
    set_req(1, 0, 0, 16'h0042, 0);
    step(1, 0);
    step(1, 0);

    // Reset in the middle of an access
    set_req(0, 1, 0, 16'h0050, 16'hBEEF);
    drive();
    @(posedge clk);
    #3;
    reset_cycle = 1;
    #1;
    chk_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("midreset_hold");
    reset_cycle = 0;
    set_req(1, 0, 0, 16'h0060, 0);
    step(2, 0);

    // Random traffic
    for (int it = 0; it < 200; it++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 9) < 6)
          set_req(p, 1'($urandom), $urandom_range(0, 9) < 3,
                  16'($urandom), 16'($urandom));
      if ($urandom_range(0, 9) == 0)
        lat = TO + int'($urandom_range(1, 3));
      else
        lat = int'($urandom_range(1, 4));
      step(lat, $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
